instr_mem_ctrl: RTL and testbench

INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

---
 rtl/instr_mem_ctrl.sv | 124 ++++++++++++
 tb/tb_instr_mem_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_mem_ctrl: loadable instruction store with a single-cycle fetch port.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module instr_mem_ctrl #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              reload,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fault,
    output logic              loaded,
    output logic [ADDR_W:0]   load_count
);

    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W:0]   load_count_q;
    logic [DATA_W-1:0] instr_q;
    logic              instr_valid_q;
    logic              fault_q;
    logic              loaded_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              load_end;
    logic              pc_in_range;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign load_ready  = (state_q != S_READY);
    // Gating with reset keeps loader traffic held during reset out of the array.
    assign accept      = load_valid & load_ready & reset;
    assign load_end    = load_last | (load_count_q == LAST_IDX);
    assign pc_in_range = ({1'b0, pc} < load_count_q);
    assign wr_idx      = load_count_q[IDX_W-1:0];
    assign rd_idx      = pc[IDX_W-1:0];

    // Storage is deliberately not reset; load_count bounds what is readable.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_idx] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            load_count_q  <= '0;
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            loaded_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_LOAD: begin
                    instr_q       <= NOP_WORD;
                    instr_valid_q <= 1'b0;
                    if (accept) begin
                        load_count_q <= load_count_q + 1'b1;
                        if (load_end) begin
                            state_q  <= S_READY;
                            loaded_q <= 1'b1;
                        end else begin
                            state_q  <= S_LOAD;
                        end
                    end
                end
                S_READY: begin
                    if (reload) begin
                        state_q       <= S_IDLE;
                        load_count_q  <= '0;
                        fault_q       <= 1'b0;
                        loaded_q      <= 1'b0;
                        instr_q       <= NOP_WORD;
                        instr_valid_q <= 1'b0;
                    end else if (fetch_req) begin
                        instr_valid_q <= 1'b1;
                        if (pc_in_range) begin
                            instr_q <= mem_q[rd_idx];
                        end else begin
                            instr_q <= NOP_WORD;
                            fault_q <= 1'b1;
                        end
                    end else begin
                        instr_q       <= NOP_WORD;
                        instr_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;
    assign loaded      = loaded_q;
    assign load_count  = load_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_mem_ctrl: directed scenarios plus randomized traffic vs a model.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_instr_mem_ctrl;

    localparam int          DATA_W = 16;
    localparam int          ADDR_W = 8;
    localparam int          DEPTH  = 32;
    localparam logic [15:0] NOP    = 16'hDEAD;

    logic              clk;
    logic              reset;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              reload;
    logic              fetch_req;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              fault;
    logic              loaded;
    logic [ADDR_W:0]   load_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a flat word array plus "how many are loaded" and "is program complete".
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                ref_count;
    bit                ref_loaded;
    bit                ref_fault;

    instr_mem_ctrl #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .NOP_WORD(NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .reload     (reload),
        .fetch_req  (fetch_req),
        .pc         (pc),
        .instr      (instr),
        .instr_valid(instr_valid),
        .fault      (fault),
        .loaded     (loaded),
        .load_count (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        reload     = 1'b0;
        fetch_req  = 1'b0;
        pc         = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic load_word(input logic [DATA_W-1:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset      = 1'b0;
        load_valid = 1'b1;
        load_data  = 16'h5A5A;
        fetch_req  = 1'b1;
        #3;
        n_cmp++;
        if ({instr_valid, fault, loaded, load_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_flags: got v/f/l/r=%b required 0001", {instr_valid, fault, loaded, load_ready});
        end
        tick();
        tick();
        n_cmp++;
        if (load_count !== 9'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d required 0", load_count);
        end
        n_cmp++;
        if (instr !== NOP) begin
            n_err++;
            $display("FAIL reset_instr: got %h required %h", instr, NOP);
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (load_count !== 9'd0 || loaded !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got count=%0d loaded=%b required 0/0", load_count, loaded);
        end
    endtask

    task automatic test_basic_load();
        do_reset();
        load_word(16'h1111, 1'b0);
        load_word(16'h2222, 1'b0);
        n_cmp++;
        if (loaded !== 1'b0 || load_count !== 9'd2 || load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_mid: got loaded=%b count=%0d ready=%b required 0/2/1", loaded, load_count, load_ready);
        end
        load_word(16'h3333, 1'b1);
        n_cmp++;
        if (loaded !== 1'b1 || load_count !== 9'd3 || load_ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done: got loaded=%b count=%0d ready=%b required 1/3/0", loaded, load_count, load_ready);
        end
        fetch_req = 1'b1;
        pc        = 8'd1;
        tick();
        n_cmp++;
        if (instr !== 16'h2222 || instr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_fetch1: got %h/%b required 2222/1", instr, instr_valid);
        end
        pc = 8'd0;
        tick();
        n_cmp++;
        if (instr !== 16'h1111 || instr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_fetch0: got %h/%b required 1111/1", instr, instr_valid);
        end
        pc = 8'd2;
        tick();
        n_cmp++;
        if (instr !== 16'h3333 || instr_valid !== 1'b1 || fault !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_fetch2: got %h/%b fault=%b required 3333/1/0", instr, instr_valid, fault);
        end
        fetch_req = 1'b0;
        tick();
        n_cmp++;
        if (instr !== NOP || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL no_fetch: got %h/%b required %h/0", instr, instr_valid, NOP);
        end
    endtask

    task automatic test_full_load();
        logic [DATA_W-1:0] w [DEPTH];
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            w[i] = DATA_W'($urandom);
            load_word(w[i], 1'b0);
            if (i == DEPTH - 2) begin
                n_cmp++;
                if (loaded !== 1'b0 || load_ready !== 1'b1 || load_count !== 9'(DEPTH - 1)) begin
                    n_err++;
                    $display("FAIL full_penult: got loaded=%b ready=%b count=%0d required 0/1/%0d", loaded, load_ready, load_count, DEPTH - 1);
                end
            end
        end
        n_cmp++;
        if (loaded !== 1'b1 || load_ready !== 1'b0 || load_count !== 9'(DEPTH)) begin
            n_err++;
            $display("FAIL full_done: got loaded=%b ready=%b count=%0d required 1/0/%0d", loaded, load_ready, load_count, DEPTH);
        end
        load_word(16'hBEEF, 1'b0);
        n_cmp++;
        if (load_count !== 9'(DEPTH) || loaded !== 1'b1) begin
            n_err++;
            $display("FAIL full_overflow: got count=%0d loaded=%b required %0d/1", load_count, loaded, DEPTH);
        end
        fetch_req = 1'b1;
        pc        = 8'(DEPTH - 1);
        tick();
        n_cmp++;
        if (instr !== w[DEPTH-1] || instr_valid !== 1'b1 || fault !== 1'b0) begin
            n_err++;
            $display("FAIL full_last_word: got %h/%b fault=%b required %h/1/0", instr, instr_valid, fault, w[DEPTH-1]);
        end
        pc = 8'(DEPTH);
        tick();
        fetch_req = 1'b0;
        n_cmp++;
        if (instr !== NOP || instr_valid !== 1'b1 || fault !== 1'b1) begin
            n_err++;
            $display("FAIL full_oob: got %h/%b fault=%b required %h/1/1", instr, instr_valid, fault, NOP);
        end
    endtask

    task automatic test_fault();
        do_reset();
        load_word(16'hA001, 1'b0);
        load_word(16'hA002, 1'b0);
        load_word(16'hA003, 1'b1);
        fetch_req = 1'b1;
        pc        = 8'd3;
        tick();
        n_cmp++;
        if (instr !== NOP || instr_valid !== 1'b1 || fault !== 1'b1) begin
            n_err++;
            $display("FAIL fault_boundary: got %h/%b fault=%b required %h/1/1", instr, instr_valid, fault, NOP);
        end
        do_reset();
        load_word(16'hA001, 1'b0);
        load_word(16'hA002, 1'b0);
        load_word(16'hA003, 1'b1);
        fetch_req = 1'b1;
        pc        = 8'd5;
        tick();
        n_cmp++;
        if (instr !== NOP || instr_valid !== 1'b1 || fault !== 1'b1) begin
            n_err++;
            $display("FAIL fault_set: got %h/%b fault=%b required %h/1/1", instr, instr_valid, fault, NOP);
        end
        pc = 8'd2;
        tick();
        n_cmp++;
        if (instr !== 16'hA003 || instr_valid !== 1'b1 || fault !== 1'b1) begin
            n_err++;
            $display("FAIL fault_sticky: got %h/%b fault=%b required a003/1/1", instr, instr_valid, fault);
        end
        fetch_req = 1'b0;
        tick();
        n_cmp++;
        if (fault !== 1'b1 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fault_idle: got fault=%b valid=%b required 1/0", fault, instr_valid);
        end
    endtask

    task automatic test_reload_priority();
        reload    = 1'b1;
        fetch_req = 1'b1;
        pc        = 8'd0;
        tick();
        reload    = 1'b0;
        fetch_req = 1'b0;
        n_cmp++;
        if ({instr_valid, loaded, fault, load_ready} !== 4'b0001 || load_count !== 9'd0 || instr !== NOP) begin
            n_err++;
            $display("FAIL reload_prio: got v/l/f/r=%b count=%0d instr=%h required 0001/0/%h",
                     {instr_valid, loaded, fault, load_ready}, load_count, instr, NOP);
        end
        reload = 1'b1;
        tick();
        reload = 1'b0;
        n_cmp++;
        if (load_count !== 9'd0 || load_ready !== 1'b1 || loaded !== 1'b0) begin
            n_err++;
            $display("FAIL reload_idle: got count=%0d ready=%b loaded=%b required 0/1/0", load_count, load_ready, loaded);
        end
        load_word(16'h4444, 1'b1);
        fetch_req = 1'b1;
        pc        = 8'd0;
        tick();
        n_cmp++;
        if (instr !== 16'h4444 || fault !== 1'b0) begin
            n_err++;
            $display("FAIL reload_newprog: got %h fault=%b required 4444/0", instr, fault);
        end
        pc = 8'd1;
        tick();
        fetch_req = 1'b0;
        n_cmp++;
        if (instr !== NOP || fault !== 1'b1) begin
            n_err++;
            $display("FAIL stale_word_hidden: got %h fault=%b required %h/1", instr, fault, NOP);
        end
    endtask

    task automatic test_reset_midload();
        logic [DATA_W-1:0] w [4];
        do_reset();
        load_word(16'h0BAD, 1'b0);
        load_word(16'h0BAE, 1'b0);
        reset      = 1'b0;
        load_valid = 1'b1;
        fetch_req  = 1'b1;
        #2;
        n_cmp++;
        if ({instr_valid, fault, loaded, load_ready} !== 4'b0001 || load_count !== 9'd0 || instr !== NOP) begin
            n_err++;
            $display("FAIL midload_reset: got v/f/l/r=%b count=%0d instr=%h required 0001/0/%h",
                     {instr_valid, fault, loaded, load_ready}, load_count, instr, NOP);
        end
        tick();
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w[i] = DATA_W'($urandom);
            load_word(w[i], (i == 3));
        end
        n_cmp++;
        if (load_count !== 9'd4 || loaded !== 1'b1) begin
            n_err++;
            $display("FAIL midload_reload: got count=%0d loaded=%b required 4/1", load_count, loaded);
        end
        fetch_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = 8'(i);
            tick();
            n_cmp++;
            if (instr !== w[i] || instr_valid !== 1'b1) begin
                n_err++;
                $display("FAIL midload_read pc=%0d: got %h/%b required %h/1", i, instr, instr_valid, w[i]);
            end
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_fetch_during_load();
        do_reset();
        fetch_req = 1'b1;
        pc        = 8'd0;
        tick();
        n_cmp++;
        if (instr_valid !== 1'b0 || fault !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_idle: got valid=%b fault=%b required 0/0", instr_valid, fault);
        end
        load_word(16'h7777, 1'b0);
        n_cmp++;
        if (instr_valid !== 1'b0 || fault !== 1'b0 || load_count !== 9'd1) begin
            n_err++;
            $display("FAIL fetch_load: got valid=%b fault=%b count=%0d required 0/0/1", instr_valid, fault, load_count);
        end
        pc     = 8'd9;
        reload = 1'b1;
        tick();
        reload = 1'b0;
        n_cmp++;
        if (load_count !== 9'd1 || instr_valid !== 1'b0 || fault !== 1'b0 || loaded !== 1'b0) begin
            n_err++;
            $display("FAIL reload_in_load: got count=%0d valid=%b fault=%b loaded=%b required 1/0/0/0",
                     load_count, instr_valid, fault, loaded);
        end
        fetch_req = 1'b0;
        load_word(16'h8888, 1'b1);
        n_cmp++;
        if (loaded !== 1'b1 || load_count !== 9'd2) begin
            n_err++;
            $display("FAIL load_resume: got loaded=%b count=%0d required 1/2", loaded, load_count);
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] exp_instr;
        bit                exp_valid;
        for (int round = 0; round < 4; round++) begin
            do_reset();
            ref_count  = 0;
            ref_loaded = 0;
            ref_fault  = 0;
            for (int cyc = 0; cyc < 150; cyc++) begin
                load_valid = 1'($urandom_range(0, 1));
                load_data  = DATA_W'($urandom);
                load_last  = ($urandom_range(0, 5) == 0);
                fetch_req  = 1'($urandom_range(0, 1));
                pc         = 8'($urandom_range(0, 40));
                reload     = ($urandom_range(0, 11) == 0);
                exp_instr  = NOP;
                exp_valid  = 0;
                if (!ref_loaded) begin
                    if (load_valid) begin
                        ref_mem[ref_count] = load_data;
                        ref_count++;
                        if (load_last || ref_count == DEPTH) ref_loaded = 1;
                    end
                end else if (reload) begin
                    ref_count  = 0;
                    ref_loaded = 0;
                    ref_fault  = 0;
                end else if (fetch_req) begin
                    exp_valid = 1;
                    if (int'(pc) < ref_count) exp_instr = ref_mem[pc];
                    else ref_fault = 1;
                end
                tick();
                n_cmp++;
                if (instr !== exp_instr || instr_valid !== exp_valid) begin
                    n_err++;
                    $display("FAIL rand_fetch r%0d c%0d: got %h/%b required %h/%b", round, cyc, instr, instr_valid, exp_instr, exp_valid);
                end
                n_cmp++;
                if (load_count !== 9'(ref_count) || loaded !== ref_loaded || load_ready !== !ref_loaded || fault !== ref_fault) begin
                    n_err++;
                    $display("FAIL rand_state r%0d c%0d: got count=%0d loaded=%b ready=%b fault=%b required %0d/%b/%b/%b",
                             round, cyc, load_count, loaded, load_ready, fault, ref_count, ref_loaded, !ref_loaded, ref_fault);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_basic_load();
        test_full_load();
        test_fault();
        test_reload_priority();
        test_reset_midload();
        test_fetch_during_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
